// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch request controller.
//
// Contents:
//   DEPTH_DEFAULT       default number of fetches that may be outstanding or buffered
//   ADDR_WIDTH_DEFAULT  default address / instruction width
//   fetch_entry_t       {pc, inst} pair delivered downstream
//   fetch_state_t       controller state: IDLE, BUSY, DRAIN
//   next_fetch_state    derives the state from the next-cycle counter values

package fetch_pkg;

   localparam int DEPTH_DEFAULT      = 2;
   localparam int ADDR_WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic [ADDR_WIDTH_DEFAULT-1:0] pc;
      logic [ADDR_WIDTH_DEFAULT-1:0] inst;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_BUSY  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_t;

   // Cancelled responses dominate: while any are still expected we are
   // draining, regardless of how many live requests are also out.
   function automatic fetch_state_t next_fetch_state(input logic live_nz,
                                                     input logic cancel_nz);
      if (cancel_nz)
         return FS_DRAIN;
      else if (live_nz)
         return FS_BUSY;
      else
         return FS_IDLE;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a clear input, used for both the pending-PC
// queue and the output buffer of the fetch controller.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (empties the FIFO)
//   clear      synchronous flush (empties the FIFO, wins over push/pop)
//   push       write push_data at the tail
//   push_data  WIDTH-bit write data
//   pop        drop the head entry
//   pop_data   head entry (valid whenever count > 0)
//   count      number of stored entries
//
// DEPTH must be a power of two so the pointers wrap naturally.

module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage has no reset; stale contents are never visible because
   // count gates every consumer.
   always_ff @(posedge clk) begin
      if (push && !rst && !clear)
         mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_req_ctrl.sv
// Instruction-fetch request controller between the fetch stage and the icache.
// Tracks issued requests, discards responses belonging to fetches killed by a
// redirect, and buffers returned {pc, inst} pairs for the decode stage.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   pc_valid, pc, uncache_in   fetch address presented by the fetch stage
//   flush                      redirect; kills every older fetch
//   pc_accept                  address taken this cycle, fetch stage advances
//   icache_valid, inst_addr,
//   inst_uncache_en            request to the icache
//   inst_addr_ok               icache accepted the request
//   inst_data_ok, inst_rdata   one in-order response from the icache
//   out_valid, out_pc, out_inst head of the output buffer
//   ns_ready                   downstream consumes the head entry

module fetch_req_ctrl
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_valid,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  uncache_in,
   input  logic                  flush,
   output logic                  pc_accept,
   output logic                  icache_valid,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_uncache_en,
   input  logic                  inst_addr_ok,
   input  logic                  inst_data_ok,
   input  logic [ADDR_WIDTH-1:0] inst_rdata,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [ADDR_WIDTH-1:0] out_inst,
   input  logic                  ns_ready
);

   localparam int CW = $clog2(DEPTH+1);

   logic [CW-1:0]           live_cnt;
   logic [CW-1:0]           cancel_cnt;
   logic [CW-1:0]           occ;
   logic [CW-1:0]           pend_cnt;
   logic [CW-1:0]           live_nxt;
   logic [CW-1:0]           cancel_nxt;
   logic [CW+1:0]           in_use;
   logic                    issue;
   logic                    resp_live;
   logic                    resp_cancel;
   logic [ADDR_WIDTH-1:0]   pend_pc;
   logic [2*ADDR_WIDTH-1:0] out_entry;
   fetch_state_t            state;

   // A request is only offered when every possible response already has a
   // buffer slot reserved, so the icache never has to be stalled on return.
   // Responses go to the cancelled count first because the icache answers
   // in order and cancelled fetches are always the oldest.
   always_comb begin
      in_use       = (CW+2)'(live_cnt) + (CW+2)'(cancel_cnt) + (CW+2)'(occ);
      icache_valid = pc_valid && !flush && !rst && (in_use < (CW+2)'(DEPTH));
      issue        = icache_valid && inst_addr_ok;
      resp_cancel  = inst_data_ok && (cancel_cnt != '0);
      resp_live    = inst_data_ok && (cancel_cnt == '0) && (live_cnt != '0);
      if (flush) begin
         live_nxt   = '0;
         cancel_nxt = cancel_cnt + live_cnt - CW'(resp_live) - CW'(resp_cancel);
      end else begin
         live_nxt   = live_cnt + CW'(issue) - CW'(resp_live);
         cancel_nxt = cancel_cnt - CW'(resp_cancel);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         live_cnt   <= '0;
         cancel_cnt <= '0;
         state      <= FS_IDLE;
      end else begin
         live_cnt   <= live_nxt;
         cancel_cnt <= cancel_nxt;
         state      <= next_fetch_state(live_nxt != '0, cancel_nxt != '0);
      end
   end

   assign pc_accept       = issue;
   assign inst_addr       = pc;
   assign inst_uncache_en = uncache_in;
   assign out_valid       = (occ != '0) && !rst;
   assign out_pc          = out_entry[2*ADDR_WIDTH-1:ADDR_WIDTH];
   assign out_inst        = out_entry[ADDR_WIDTH-1:0];

   fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_pend_q (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (issue),
      .push_data (pc),
      .pop       (resp_live),
      .pop_data  (pend_pc),
      .count     (pend_cnt)
   );

   // A live response coincident with a flush is pushed here but the clear
   // wins, so it never reaches the decode stage.
   fetch_fifo #(.WIDTH(2*ADDR_WIDTH), .DEPTH(DEPTH)) u_out_q (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (resp_live),
      .push_data ({pend_pc, inst_rdata}),
      .pop       (out_valid && ns_ready),
      .pop_data  (out_entry),
      .count     (occ)
   );

   a_no_orphan_resp : assert property (@(posedge clk) disable iff (rst)
      inst_data_ok |-> (live_cnt != '0 || cancel_cnt != '0));

   a_within_depth : assert property (@(posedge clk) disable iff (rst)
      in_use <= (CW+2)'(DEPTH));

   a_pend_tracks_live : assert property (@(posedge clk) disable iff (rst)
      pend_cnt == live_cnt);

endmodule
